cart_loader: RTL and testbench

Cartridge ROM loader between `data_io` and the `sdram` write port. Takes the byte stream from an OSD file download and turns it into toggle-handshaked SDRAM writes, pacing the host with `ioctl_wait`. At end of download it decides whether the file has a 512-byte copier header and computes the power-of-two cartridge address mask. It also latches the Game Gear flag and holds the system in reset while loading.

---
 rtl/cart_pkg.sv | 22 ++
 rtl/cart_loader_toggle_req.sv | 47 ++++
 rtl/cart_loader.sv | 155 +++++++++++++++
 tb/tb_cart_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared constants and helpers for the cartridge ROM loader.
package cart_pkg;

  localparam int         HDR_BYTES_DFLT = 512;
  localparam logic [1:0] GG_INDEX       = 2'd2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Set every bit below the most significant one.
  function automatic logic [31:0] smear_mask(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 30; i >= 0; i--) r[i] = r[i] | r[i+1];
    return r;
  endfunction

endpackage

// File: rtl/cart_loader_toggle_req.sv
// Toggle-handshake SDRAM write requester with a one-entry skid buffer.
module toggle_req #(
  parameter int ADDR_W = 22
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clr,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_data,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  input  logic              mem_we_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_din,
  output logic              pending,
  output logic              skid_full,
  output logic [7:0]        skid_data
);

  assign pending = mem_we ^ mem_we_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_din   <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else begin
      if (req) begin
        mem_we    <= ~mem_we;
        mem_waddr <= req_addr;
        mem_din   <= req_data;
      end
      // A push in the same cycle as a pop refills the entry just drained.
      if (clr) skid_full <= 1'b0;
      else if (push) begin
        skid_full <= 1'b1;
        skid_data <= push_data;
      end else if (pop) skid_full <= 1'b0;
    end
  end

endmodule

// File: rtl/cart_loader.sv
// Cartridge ROM loader: data_io byte stream to SDRAM writes, header/mask detection.
module cart_loader
  import cart_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int HDR_BYTES = HDR_BYTES_DFLT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_we_ack,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              cart_hdr,
  output logic              cart_gg,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_ovf
);

  localparam int              HDR_LOG = $clog2(HDR_BYTES);
  localparam logic [ADDR_W:0] LIMIT   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] HDR_SZ  = (ADDR_W+1)'(HDR_BYTES);

  logic [2:0]        state, nstate;
  logic              dl_q, dl_rise;
  logic [ADDR_W:0]   count, cnt_p1, plen;
  logic              req, push, pop, clr, cnt_inc, ovf_set, fin;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_data;
  logic              pending, skid_full, hdr_n;
  logic [7:0]        skid_data;
  logic              unused_idx;

  assign unused_idx = ^ioctl_index[5:0];
  assign dl_rise    = ioctl_download & ~dl_q;
  assign cnt_p1     = count + ONE;
  assign hdr_n      = count[HDR_LOG];
  assign plen       = hdr_n ? count - HDR_SZ : count;

  always_comb begin
    nstate   = state;
    req      = 1'b0;
    req_addr = count[ADDR_W-1:0];
    req_data = ioctl_dout;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    cnt_inc  = 1'b0;
    ovf_set  = 1'b0;
    fin      = 1'b0;
    if (dl_rise) begin
      clr    = 1'b1;
      nstate = pending ? S_SYNC : S_ACCEPT;
    end else begin
      case (state)
        S_SYNC: if (!pending) nstate = S_ACCEPT;
        S_ACCEPT:
          if (ioctl_wr) begin
            if (count == LIMIT) ovf_set = 1'b1;
            else begin
              req    = 1'b1;
              nstate = S_WRITE;
            end
          end else if (!ioctl_download) nstate = S_FINISH;
        S_WRITE:
          if (!pending) begin
            cnt_inc  = 1'b1;
            req_addr = cnt_p1[ADDR_W-1:0];
            // Address space just filled: anything buffered or arriving is lost.
            if (cnt_p1 == LIMIT) begin
              ovf_set = skid_full | ioctl_wr;
              pop     = 1'b1;
              nstate  = S_ACCEPT;
            end else if (skid_full) begin
              req      = 1'b1;
              req_data = skid_data;
              push     = ioctl_wr;
              pop      = ~ioctl_wr;
            end else if (ioctl_wr) req = 1'b1;
            else nstate = S_ACCEPT;
          end else if (ioctl_wr) begin
            push    = ~skid_full;
            ovf_set = skid_full;
          end
        S_FINISH: begin
          fin    = 1'b1;
          nstate = S_DONE;
        end
        S_DONE:  nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      count      <= '0;
      load_ovf   <= 1'b0;
      cart_gg    <= 1'b0;
      cart_hdr   <= 1'b0;
      cart_mask  <= '0;
      load_done  <= 1'b0;
      ioctl_wait <= 1'b1;
      load_busy  <= 1'b1;
    end else begin
      state      <= nstate;
      dl_q       <= ioctl_download;
      ioctl_wait <= (nstate == S_SYNC) || (nstate == S_WRITE);
      load_busy  <= (nstate != S_IDLE);
      load_done  <= fin;
      if (dl_rise) begin
        count    <= '0;
        load_ovf <= 1'b0;
        cart_gg  <= (ioctl_index[7:6] == GG_INDEX);
      end else begin
        if (cnt_inc) count <= cnt_p1;
        if (ovf_set) load_ovf <= 1'b1;
      end
      if (fin) begin
        cart_hdr  <= hdr_n;
        cart_mask <= (plen > ONE) ? ADDR_W'(smear_mask(32'(plen - ONE))) : '0;
      end
    end
  end

  toggle_req #(.ADDR_W(ADDR_W)) u_req (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .clr        (clr),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .push       (ioctl_wr & push),
    .push_data  (ioctl_dout),
    .pop        (pop),
    .mem_we_ack (mem_we_ack),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .pending    (pending),
    .skid_full  (skid_full),
    .skid_data  (skid_data)
  );

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader with a small address space and a latency-programmable SDRAM ack.
module tb_cart_loader;

  localparam int AW = 12;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'h00;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic          ioctl_wait;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_we_ack;
  logic [AW-1:0] cart_mask;
  logic          cart_hdr, cart_gg, load_busy, load_done, load_ovf;

  int vecs = 0;
  int errs = 0;

  cart_loader #(.ADDR_W(AW), .HDR_BYTES(512)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_we_ack(mem_we_ack), .cart_mask(cart_mask),
    .cart_hdr(cart_hdr), .cart_gg(cart_gg), .load_busy(load_busy), .load_done(load_done),
    .load_ovf(load_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: ack follows mem_we after lat cycles; lat 0 acks combinationally.
  int   lat = 0;
  int   ack_cnt;
  logic ack_q;
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      ack_cnt <= 0;
    end else if (mem_we !== ack_q) begin
      if (ack_cnt + 1 >= lat) begin
        ack_q   <= mem_we;
        ack_cnt <= 0;
      end else ack_cnt <= ack_cnt + 1;
    end
  end
  assign mem_we_ack = (lat == 0) ? mem_we : ack_q;

  // Write log: one entry per mem_we toggle.
  logic          prev_we = 1'b0;
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];
  always @(negedge clk_sys) begin
    if (!reset && mem_we !== prev_we) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_din);
    end
    prev_we <= mem_we;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i ^ (i >> 8) ^ 8'h5A);
  endfunction

  function automatic int log_bad(input int n);
    int b = 0;
    if (log_addr.size() != n) b++;
    for (int j = 0; j < log_addr.size(); j++)
      if (log_addr[j] !== AW'(j) || log_data[j] !== pat(j)) b++;
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk_sys);
    while (ioctl_wait && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    if (ioctl_wait) begin
      vecs++; errs++;
      $display("FAIL wait_timeout: ioctl_wait stuck at %b, want 0", ioctl_wait);
    end
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic force_byte(input logic [7:0] b);
    @(negedge clk_sys);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    log_addr.delete();
    log_data.delete();
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl(output logic [AW-1:0] m, output logic h, output int pulses);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    pulses = 0;
    m = '1;
    h = 1'bx;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_sys);
      if (load_done) begin
        pulses++;
        m = cart_mask;
        h = cart_hdr;
      end
    end
  endtask

  task automatic run_dl(input logic [7:0] idx, input int n, output logic [AW-1:0] m,
                        output logic h, output int pulses);
    start_dl(idx);
    for (int i = 0; i < n; i++) send_byte(pat(i));
    end_dl(m, h, pulses);
  endtask

  task automatic check_reset_vals(input string tag);
    vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL %s mem_we: got %b want 0", tag, mem_we); end
    vecs++; if (mem_waddr !== '0) begin errs++; $display("FAIL %s mem_waddr: got %h want 0", tag, mem_waddr); end
    vecs++; if (mem_din !== 8'h00) begin errs++; $display("FAIL %s mem_din: got %h want 0", tag, mem_din); end
    vecs++; if (cart_mask !== '0) begin errs++; $display("FAIL %s cart_mask: got %h want 0", tag, cart_mask); end
    vecs++; if (cart_hdr !== 1'b0) begin errs++; $display("FAIL %s cart_hdr: got %b want 0", tag, cart_hdr); end
    vecs++; if (cart_gg !== 1'b0) begin errs++; $display("FAIL %s cart_gg: got %b want 0", tag, cart_gg); end
    vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL %s load_done: got %b want 0", tag, load_done); end
    vecs++; if (load_ovf !== 1'b0) begin errs++; $display("FAIL %s load_ovf: got %b want 0", tag, load_ovf); end
    vecs++; if (ioctl_wait !== 1'b1) begin errs++; $display("FAIL %s ioctl_wait: got %b want 1", tag, ioctl_wait); end
    vecs++; if (load_busy !== 1'b1) begin errs++; $display("FAIL %s load_busy: got %b want 1", tag, load_busy); end
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    check_reset_vals("reset");
    reset = 1'b0;
    #1;
    vecs++; if (ioctl_wait !== 1'b1) begin errs++; $display("FAIL rel_wait_hold: got %b want 1", ioctl_wait); end
    @(negedge clk_sys);
    vecs++; if (ioctl_wait !== 1'b0) begin errs++; $display("FAIL rel_wait_drop: got %b want 0", ioctl_wait); end
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL rel_busy: got %b want 0", load_busy); end
  endtask

  task automatic test_plain();
    logic [AW-1:0] m; logic h; int p, b;
    lat = 0;
    run_dl(8'h00, 1024, m, h, p);
    b = log_bad(1024);
    vecs++; if (b !== 0) begin errs++; $display("FAIL plain_writes: %0d bad of %0d, want 0", b, log_addr.size()); end
    vecs++; if (p !== 1) begin errs++; $display("FAIL plain_done_pulses: got %0d want 1", p); end
    vecs++; if (h !== 1'b0) begin errs++; $display("FAIL plain_hdr: got %b want 0", h); end
    vecs++; if (m !== 12'h3FF) begin errs++; $display("FAIL plain_mask: got %h want 3ff", m); end
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL plain_busy: got %b want 0", load_busy); end
  endtask

  task automatic test_header();
    logic [AW-1:0] m; logic h; int p, b;
    run_dl(8'h00, 512 + 2048, m, h, p);
    b = log_bad(2560);
    vecs++; if (b !== 0) begin errs++; $display("FAIL hdr_writes: %0d bad, want 0", b); end
    vecs++; if (h !== 1'b1) begin errs++; $display("FAIL hdr_flag: got %b want 1", h); end
    vecs++; if (m !== 12'h7FF) begin errs++; $display("FAIL hdr_mask: got %h want 7ff", m); end
  endtask

  task automatic test_odd_size();
    logic [AW-1:0] m; logic h; int p;
    run_dl(8'h00, 3072, m, h, p);
    vecs++; if (h !== 1'b0) begin errs++; $display("FAIL odd_hdr: got %b want 0", h); end
    vecs++; if (m !== 12'hFFF) begin errs++; $display("FAIL odd_mask: got %h want fff", m); end
    vecs++; if (load_ovf !== 1'b0) begin errs++; $display("FAIL odd_ovf: got %b want 0", load_ovf); end
  endtask

  task automatic test_saturate();
    logic [AW-1:0] m; logic h; int p, b;
    run_dl(8'h00, 4098, m, h, p);
    b = log_bad(4096);
    vecs++; if (b !== 0) begin errs++; $display("FAIL sat_writes: %0d bad of %0d, want 0", b, log_addr.size()); end
    vecs++; if (load_ovf !== 1'b1) begin errs++; $display("FAIL sat_ovf: got %b want 1", load_ovf); end
    vecs++; if (m !== 12'hFFF) begin errs++; $display("FAIL sat_mask: got %h want fff", m); end
    vecs++; if (h !== 1'b0) begin errs++; $display("FAIL sat_hdr: got %b want 0", h); end
  endtask

  task automatic test_skid();
    logic [AW-1:0] m; logic h; int p, b;
    lat = 7;
    start_dl(8'h00);
    send_byte(pat(0));
    force_byte(pat(1));
    @(negedge clk_sys);
    vecs++; if (ioctl_wait !== 1'b1) begin errs++; $display("FAIL skid_wait: got %b want 1", ioctl_wait); end
    send_byte(pat(2));
    send_byte(pat(3));
    end_dl(m, h, p);
    b = log_bad(4);
    vecs++; if (b !== 0) begin errs++; $display("FAIL skid_writes: %0d bad of %0d, want 0", b, log_addr.size()); end
    vecs++; if (load_ovf !== 1'b0) begin errs++; $display("FAIL skid_ovf: got %b want 0", load_ovf); end
    vecs++; if (m !== 12'h003) begin errs++; $display("FAIL skid_mask: got %h want 003", m); end
    start_dl(8'h00);
    send_byte(pat(0));
    force_byte(pat(1));
    force_byte(pat(2));
    end_dl(m, h, p);
    b = log_bad(2);
    vecs++; if (b !== 0) begin errs++; $display("FAIL drop_writes: %0d bad of %0d, want 0", b, log_addr.size()); end
    vecs++; if (load_ovf !== 1'b1) begin errs++; $display("FAIL drop_ovf: got %b want 1", load_ovf); end
    vecs++; if (m !== 12'h001) begin errs++; $display("FAIL drop_mask: got %h want 001", m); end
  endtask

  task automatic test_gg();
    logic [AW-1:0] m; logic h; int p;
    lat = 0;
    run_dl(8'h80, 16, m, h, p);
    vecs++; if (cart_gg !== 1'b1) begin errs++; $display("FAIL gg_set: got %b want 1", cart_gg); end
    vecs++; if (m !== 12'h00F) begin errs++; $display("FAIL gg_mask: got %h want 00f", m); end
    run_dl(8'h01, 5, m, h, p);
    vecs++; if (cart_gg !== 1'b0) begin errs++; $display("FAIL gg_clear: got %b want 0", cart_gg); end
    vecs++; if (m !== 12'h007) begin errs++; $display("FAIL gg_mask2: got %h want 007", m); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] m; logic h; int p, b;
    lat = 7;
    run_dl(8'h80, 16, m, h, p);
    start_dl(8'h80);
    for (int i = 0; i < 3; i++) send_byte(pat(i));
    @(negedge clk_sys);
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk_sys);
    reset = 1'b0;
    lat = 0;
    run_dl(8'h00, 256, m, h, p);
    b = log_bad(256);
    vecs++; if (b !== 0) begin errs++; $display("FAIL rst_writes: %0d bad of %0d, want 0", b, log_addr.size()); end
    vecs++; if (p !== 1) begin errs++; $display("FAIL rst_done_pulses: got %0d want 1", p); end
    vecs++; if (m !== 12'h0FF) begin errs++; $display("FAIL rst_mask: got %h want 0ff", m); end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_header();
    test_odd_size();
    test_saturate();
    test_skid();
    test_gg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
